// File: rtl/addsub_share_arbiter_if.sv
// Request/response bundle between the two operand sequencers and the shared
// add/sub arbiter. The master side is the sequencer pair; the slave side is the arbiter.
interface addsub_share_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;
  logic             rsp0_valid;
  logic             rsp0_ack;
  logic [WIDTH-1:0] rsp0_sumdiff;
  logic             rsp0_carryborrow;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;
  logic             rsp1_valid;
  logic             rsp1_ack;
  logic [WIDTH-1:0] rsp1_sumdiff;
  logic             rsp1_carryborrow;

  logic             busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub, rsp0_ack,
    output req1_valid, req1_a, req1_b, req1_sub, rsp1_ack,
    input  req0_ready, rsp0_valid, rsp0_sumdiff, rsp0_carryborrow,
    input  req1_ready, rsp1_valid, rsp1_sumdiff, rsp1_carryborrow,
    input  busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub, rsp0_ack,
    input  req1_valid, req1_a, req1_b, req1_sub, rsp1_ack,
    output req0_ready, rsp0_valid, rsp0_sumdiff, rsp0_carryborrow,
    output req1_ready, rsp1_valid, rsp1_sumdiff, rsp1_carryborrow,
    output busy
  );
endinterface

// File: rtl/addsub_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder/subtractor between two requesters;
// each accepted operation runs IDLE -> EXEC -> RESP and returns a held result.
module addsub_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  addsub_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg;
  logic             ptr_reg;
  logic             owner_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic             op_sub_reg;
  logic [1:0]       rsp_valid_reg;
  logic [1:0]       rsp_cb_reg;
  logic [WIDTH-1:0] rsp_sumdiff_reg [2];

  logic [1:0]       req_valid;
  logic [1:0]       req_sub;
  logic [1:0]       rsp_ack;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a [2];
  logic [WIDTH-1:0] req_b [2];

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign req_sub   = {bus.req1_sub, bus.req0_sub};
  assign rsp_ack   = {bus.rsp1_ack, bus.rsp0_ack};
  assign req_a[0]  = bus.req0_a;
  assign req_a[1]  = bus.req1_a;
  assign req_b[0]  = bus.req0_b;
  assign req_b[1]  = bus.req1_b;

  // A lone requester always wins; on contention the pointer decides.
  logic winner;
  logic grant_any;

  always_comb begin
    winner = ptr_reg;
    if (req_valid == 2'b01) begin
      winner = 1'b0;
    end else if (req_valid == 2'b10) begin
      winner = 1'b1;
    end
  end

  assign grant_any = (state_reg == IDLE) && (|req_valid) && !rst;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = grant_any && (winner == (gi == 1));
    end
  endgenerate

  // Subtraction is a + ~b + 1, so the carry out reads as "no borrow".
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   result;

  assign b_eff  = op_b_reg ^ {WIDTH{op_sub_reg}};
  assign result = {1'b0, op_a_reg} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      ptr_reg            <= 1'b0;
      owner_reg          <= 1'b0;
      busy_reg           <= 1'b0;
      op_a_reg           <= '0;
      op_b_reg           <= '0;
      op_sub_reg         <= 1'b0;
      rsp_valid_reg      <= 2'b00;
      rsp_cb_reg         <= 2'b00;
      rsp_sumdiff_reg[0] <= '0;
      rsp_sumdiff_reg[1] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_any) begin
            owner_reg  <= winner;
            op_a_reg   <= req_a[winner];
            op_b_reg   <= req_b[winner];
            op_sub_reg <= req_sub[winner];
            busy_reg   <= 1'b1;
            state_reg  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sumdiff_reg[owner_reg] <= result[WIDTH-1:0];
          rsp_cb_reg[owner_reg]      <= result[WIDTH];
          rsp_valid_reg[owner_reg]   <= 1'b1;
          state_reg                  <= RESP;
        end
        RESP: begin
          // Only the owner's ack closes the transaction.
          if (rsp_ack[owner_reg]) begin
            rsp_valid_reg[owner_reg] <= 1'b0;
            ptr_reg                  <= ~owner_reg;
            busy_reg                 <= 1'b0;
            state_reg                <= IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready       = req_ready[0];
  assign bus.req1_ready       = req_ready[1];
  assign bus.rsp0_valid       = rsp_valid_reg[0];
  assign bus.rsp1_valid       = rsp_valid_reg[1];
  assign bus.rsp0_sumdiff     = rsp_sumdiff_reg[0];
  assign bus.rsp1_sumdiff     = rsp_sumdiff_reg[1];
  assign bus.rsp0_carryborrow = rsp_cb_reg[0];
  assign bus.rsp1_carryborrow = rsp_cb_reg[1];
  assign bus.busy             = busy_reg;

endmodule
